// File: rtl/simmem_pkg.sv
// simmem_pkg: shared widths, types and slot record for the simmem release scheduler.
package simmem_pkg;
  localparam int IDWidth       = 4;
  localparam int NumIds        = 2 ** IDWidth;
  localparam int DelayWidth    = 8;
  localparam int NumSlots      = 8;
  localparam int TotalCapacity = 16;
  localparam int CreditWidth   = $clog2(TotalCapacity + 1);
  localparam int OccWidth      = $clog2(NumSlots + 1);
  typedef logic [IDWidth-1:0]     id_t;
  typedef logic [DelayWidth-1:0]  delay_t;
  typedef logic [CreditWidth-1:0] credit_t;
  typedef logic [OccWidth-1:0]    occ_t;
  typedef struct packed {
    logic   valid;
    id_t    id;
    delay_t cnt;
  } slot_t;
endpackage

// File: rtl/simmem_release_scheduler_if.sv
// simmem_release_scheduler_if: request handshake and per-ID release credit signals.
interface simmem_release_scheduler_if;
  import simmem_pkg::*;
  id_t               req_id_i;
  delay_t            req_delay_i;
  logic              req_valid_i;
  logic              req_ready_o;
  logic [NumIds-1:0] release_en_o;
  logic [NumIds-1:0] released_i;
  modport master (output req_id_i, req_delay_i, req_valid_i, released_i, input req_ready_o, release_en_o);
  modport slave  (input req_id_i, req_delay_i, req_valid_i, released_i, output req_ready_o, release_en_o);
endinterface

// File: rtl/simmem_delay_slot.sv
// simmem_delay_slot: one countdown slot; expire_o is high during the cycle whose closing edge frees it.
module simmem_delay_slot
  import simmem_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   load_i,
  input  id_t    id_i,
  input  delay_t delay_i,
  output logic   valid_o,
  output id_t    id_o,
  output logic   expire_o
);
  slot_t slot_q, slot_d;
  assign expire_o = slot_q.valid && (slot_q.cnt == '0);
  assign valid_o  = slot_q.valid;
  assign id_o     = slot_q.id;
  assign slot_d   = load_i       ? '{valid: 1'b1, id: id_i, cnt: delay_i} :
                    expire_o     ? '{valid: 1'b0, id: slot_q.id, cnt: slot_q.cnt} :
                    slot_q.valid ? '{valid: 1'b1, id: slot_q.id, cnt: slot_q.cnt - delay_t'(1)} :
                                   slot_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) slot_q <= '0;
    else         slot_q <= slot_d;
  end
endmodule

// File: rtl/simmem_release_scheduler.sv
// simmem_release_scheduler: delays requests in countdown slots and grants per-ID release credits on expiry.
// Define SIMMEM_RELEASE_SCHED_STATS_EN to add occupancy, high-water and stall statistics outputs.
module simmem_release_scheduler
  import simmem_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  simmem_release_scheduler_if.slave bus
`ifdef SIMMEM_RELEASE_SCHED_STATS_EN
  ,
  output occ_t        occupancy_o,
  output occ_t        max_occupancy_o,
  output logic [31:0] stall_cnt_o
`endif
);
  logic [NumSlots-1:0] valid, expire, free, grant;
  id_t                 slot_id [NumSlots];
  credit_t             credit_q [NumIds];
  credit_t             credit_d [NumIds];
  occ_t                inc [NumIds];
  logic [NumIds-1:0]   dec;
  assign free            = ~valid;
  assign bus.req_ready_o = |free;
  // isolate the lowest set bit of free
  assign grant = (bus.req_valid_i && bus.req_ready_o) ? (free & (~free + NumSlots'(1))) : '0;
  for (genvar s = 0; s < NumSlots; s++) begin : g_slot
    simmem_delay_slot u_slot (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .load_i   (grant[s]),
      .id_i     (bus.req_id_i),
      .delay_i  (bus.req_delay_i),
      .valid_o  (valid[s]),
      .id_o     (slot_id[s]),
      .expire_o (expire[s])
    );
  end
  always_comb begin
    for (int i = 0; i < NumIds; i++) begin
      inc[i] = '0;
      for (int j = 0; j < NumSlots; j++) inc[i] = inc[i] + occ_t'(expire[j] && (slot_id[j] == id_t'(i)));
      dec[i]      = bus.released_i[i] && (credit_q[i] != '0);
      credit_d[i] = credit_q[i] + credit_t'(inc[i]) - credit_t'(dec[i]);
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) credit_q <= '{default: '0};
    else         credit_q <= credit_d;
  end
  for (genvar g = 0; g < NumIds; g++) begin : g_en
    assign bus.release_en_o[g] = (credit_q[g] != '0);
  end
  always @(posedge clk_i) begin
    if (rst_ni) begin
      for (int i = 0; i < NumIds; i++) begin
        assert (!(bus.released_i[i] && (credit_q[i] == '0)))
          else $warning("release pulse on id %0d with zero credit ignored", i);
        assert (int'(credit_q[i]) + int'(inc[i]) <= TotalCapacity)
          else $error("credit overflow on id %0d", i);
      end
    end
  end
`ifdef SIMMEM_RELEASE_SCHED_STATS_EN
  occ_t        occ, max_q;
  logic [31:0] stall_q;
  always_comb begin
    occ = '0;
    for (int j = 0; j < NumSlots; j++) occ = occ + occ_t'(valid[j]);
  end
  assign occupancy_o     = occ;
  assign max_occupancy_o = (occ > max_q) ? occ : max_q;
  assign stall_cnt_o     = stall_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      max_q   <= '0;
      stall_q <= '0;
    end else begin
      max_q   <= max_occupancy_o;
      stall_q <= (bus.req_valid_i && !bus.req_ready_o && (stall_q != '1)) ? stall_q + 32'd1 : stall_q;
    end
  end
`endif
endmodule

// File: tb/tb_simmem_release_scheduler.sv
// tb_simmem_release_scheduler: scoreboard of per-request due cycles against release_en_o, plus scenario checks.
module tb_simmem_release_scheduler;
  import simmem_pkg::*;
  typedef struct {
    id_t id;
    int  due;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  exp_t sb[$];
  int   cred[NumIds];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  always #5 clk = ~clk;
  simmem_release_scheduler_if bus();
`ifdef SIMMEM_RELEASE_SCHED_STATS_EN
  occ_t        occupancy, max_occupancy;
  logic [31:0] stall_cnt;
`endif
  simmem_release_scheduler dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
`ifdef SIMMEM_RELEASE_SCHED_STATS_EN
    ,
    .occupancy_o     (occupancy),
    .max_occupancy_o (max_occupancy),
    .stall_cnt_o     (stall_cnt)
`endif
  );
  // advance one edge, retire due entries into the credit model and compare the whole enable vector
  task automatic tick();
    logic [NumIds-1:0] rel, want;
    rel = bus.released_i;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NumIds; i++) if (rel[i] && cred[i] > 0) cred[i]--;
    for (int k = sb.size() - 1; k >= 0; k--)
      if (sb[k].due == cyc) begin
        cred[sb[k].id]++;
        sb.delete(k);
      end
    for (int i = 0; i < NumIds; i++) want[i] = (cred[i] != 0);
    total++;
    if (bus.release_en_o !== want) begin
      bad++;
      $display("FAIL scoreboard cyc=%0d release_en got=%h want=%h", cyc, bus.release_en_o, want);
    end
  endtask
  task automatic send(input id_t id, input delay_t d, output int waited);
    bus.req_id_i    = id;
    bus.req_delay_i = d;
    bus.req_valid_i = 1'b1;
    waited = 0;
    while (!bus.req_ready_o && waited < 1000) begin
      tick();
      waited++;
    end
    tick();
    bus.req_valid_i = 1'b0;
    sb.push_back('{id: id, due: cyc + int'(d) + 1});
  endtask
  task automatic release_id(input id_t id);
    bus.released_i = NumIds'(1) << id;
    tick();
    bus.released_i = '0;
  endtask
  task automatic drain(input int lim);
    int n = 0;
    while (sb.size() != 0 && n < lim) begin
      tick();
      n++;
    end
  endtask
  task automatic test_reset();
    #12;
    total++;
    if (bus.release_en_o !== '0) begin bad++; $display("FAIL reset_en got=%h want=0", bus.release_en_o); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    total++;
    if (bus.req_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", bus.req_ready_o); end
  endtask
  task automatic test_single();
    int w;
    send(4'd3, 8'd5, w);
    total++;
    if (bus.release_en_o[3] !== 1'b0) begin bad++; $display("FAIL single_early got=%b want=0", bus.release_en_o[3]); end
    repeat (6) tick();
    total++;
    if (bus.release_en_o[3] !== 1'b1) begin bad++; $display("FAIL single_rise got=%b want=1", bus.release_en_o[3]); end
    release_id(4'd3);
    total++;
    if (bus.release_en_o[3] !== 1'b0) begin bad++; $display("FAIL single_drop got=%b want=0", bus.release_en_o[3]); end
  endtask
  task automatic test_delay_bounds();
    int w;
    send(4'd0, 8'd0, w);
    tick();
    total++;
    if (bus.release_en_o[0] !== 1'b1) begin bad++; $display("FAIL delay0 got=%b want=1", bus.release_en_o[0]); end
    release_id(4'd0);
    send(4'd5, 8'd255, w);
    repeat (255) tick();
    total++;
    if (bus.release_en_o[5] !== 1'b0) begin bad++; $display("FAIL delay255_early got=%b want=0", bus.release_en_o[5]); end
    tick();
    total++;
    if (bus.release_en_o[5] !== 1'b1) begin bad++; $display("FAIL delay255_rise got=%b want=1", bus.release_en_o[5]); end
    release_id(4'd5);
  endtask
  task automatic test_full();
    int w;
    send(4'd8, 8'd20, w);
    for (int j = 1; j < 8; j++) send(id_t'(8 + j), 8'd40, w);
    total++;
    if (bus.req_ready_o !== 1'b0) begin bad++; $display("FAIL full_ready got=%b want=0", bus.req_ready_o); end
    send(4'd1, 8'd0, w);
    total++;
    if (w !== 14) begin bad++; $display("FAIL full_stall got=%0d want=14", w); end
    drain(200);
    total++;
    if (sb.size() !== 0) begin bad++; $display("FAIL full_drain got=%0d want=0", sb.size()); end
    total++;
    if (bus.req_ready_o !== 1'b1) begin bad++; $display("FAIL full_ready_after got=%b want=1", bus.req_ready_o); end
    release_id(4'd1);
    for (int j = 8; j < 16; j++) release_id(id_t'(j));
    total++;
    if (bus.release_en_o !== '0) begin bad++; $display("FAIL full_clear got=%h want=0", bus.release_en_o); end
  endtask
  task automatic test_same_id();
    int w;
    for (int j = 0; j < 3; j++) send(4'd7, 8'd4, w);
    repeat (6) tick();
    release_id(4'd7);
    release_id(4'd7);
    total++;
    if (bus.release_en_o[7] !== 1'b1) begin bad++; $display("FAIL same_id_two got=%b want=1", bus.release_en_o[7]); end
    release_id(4'd7);
    total++;
    if (bus.release_en_o[7] !== 1'b0) begin bad++; $display("FAIL same_id_three got=%b want=0", bus.release_en_o[7]); end
    send(4'd6, 8'd3, w);
    send(4'd6, 8'd2, w);
    drain(20);
    release_id(4'd6);
    total++;
    if (bus.release_en_o[6] !== 1'b1) begin bad++; $display("FAIL popcount_one got=%b want=1", bus.release_en_o[6]); end
    release_id(4'd6);
    total++;
    if (bus.release_en_o[6] !== 1'b0) begin bad++; $display("FAIL popcount_two got=%b want=0", bus.release_en_o[6]); end
    send(4'd7, 8'd0, w);
    send(4'd7, 8'd1, w);
    tick();
    release_id(4'd7);
    total++;
    if (bus.release_en_o[7] !== 1'b1) begin bad++; $display("FAIL net_out got=%b want=1", bus.release_en_o[7]); end
    release_id(4'd7);
    total++;
    if (bus.release_en_o[7] !== 1'b0) begin bad++; $display("FAIL net_out_drop got=%b want=0", bus.release_en_o[7]); end
  endtask
  task automatic test_zero_credit();
    release_id(4'd2);
    total++;
    if (bus.release_en_o[2] !== 1'b0) begin bad++; $display("FAIL zero_credit got=%b want=0", bus.release_en_o[2]); end
    tick();
    total++;
    if (bus.release_en_o[2] !== 1'b0) begin bad++; $display("FAIL zero_credit_hold got=%b want=0", bus.release_en_o[2]); end
  endtask
  task automatic test_reset_mid();
    int w;
    send(4'd10, 8'd0, w);
    send(4'd11, 8'd0, w);
    for (int j = 1; j < 5; j++) send(id_t'(j), 8'd50, w);
    total++;
    if (bus.release_en_o[11:10] !== 2'b11) begin bad++; $display("FAIL mid_credits got=%b want=11", bus.release_en_o[11:10]); end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.release_en_o !== '0) begin bad++; $display("FAIL mid_reset_en got=%h want=0", bus.release_en_o); end
    sb.delete();
    for (int i = 0; i < NumIds; i++) cred[i] = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (300) tick();
    total++;
    if (bus.req_ready_o !== 1'b1) begin bad++; $display("FAIL mid_ready got=%b want=1", bus.req_ready_o); end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end
  initial begin
    bus.req_id_i    = '0;
    bus.req_delay_i = '0;
    bus.req_valid_i = 1'b0;
    bus.released_i  = '0;
    for (int i = 0; i < NumIds; i++) cred[i] = 0;
    test_reset();
    test_single();
    test_delay_bounds();
    test_full();
    test_same_id();
    test_zero_credit();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/simmem_release_scheduler.md
Name: simmem_release_scheduler

Overview:
- Upstream neighbour of simmem_linkedlist_bank; sole producer of the bank's per-ID release_en vector.
- Accepts request descriptors (AXI ID + programmed delay) and holds each in a countdown slot.
- On expiry, grants one release credit to that ID. The bank consumes credits as it emits responses.
- Models memory latency in the simulated memory controller; responses per ID leave in bank order.

Parameters:
- IDWidth, 4, AXI identifier width; NumIds = 2**IDWidth.
- NumSlots, 8, number of concurrently pending delayed requests.
- DelayWidth, 8, width of the per-request delay field, in cycles.
- TotalCapacity, 16, bank capacity; sets credit counter width $clog2(TotalCapacity+1).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_id_i  in  IDWidth  ID of incoming request.
- req_delay_i  in  DelayWidth  delay in cycles.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  a free slot exists.
- release_en_o  out  NumIds  bit i high while ID i holds at least one credit.
- released_i  in  NumIds  one-hot pulse from the bank: one response of ID i was output this cycle.

Behaviour:
- Reset: one clock, clk_i; reset is asynchronous, active-low (rst_ni).
  - Reset clears all slot valids, counters and credits.
  - Outputs during/after reset: release_en_o='0, req_ready_o=1 once out of reset.
  - Reset mid-operation drops all pending slots and credits; no release is emitted for them.
- Accept: handshake on req_valid_i && req_ready_o at a rising edge.
  - req_ready_o = OR of free slots, combinational from state only; it must not depend on req_valid_i.
  - The request is stored in the lowest-index free slot: valid=1, id, cnt=req_delay_i.
- Countdown, per valid slot each cycle:
  - cnt==0: slot frees and credit[id] increments at that edge.
  - cnt!=0: cnt decrements.
  - Latency: accepted at edge k with delay D, credit visible (release_en_o high) after edge k+D+1. D=0 gives 1 cycle; D=255 gives 256 cycles.
  - No wrap-around; a counter never decrements below 0.
- Slot reuse: a slot freeing at edge k is reported free only after edge k (registered). This gives no same-cycle free+accept on one slot.
- Credits, per ID, same cycle:
  - credit_d = credit_q + (number of slots of that ID expiring) - released_i[id].
  - Several same-ID slots expiring together add their popcount.
  - Simultaneous expiry and release net out.
- release_en_o[i] = (credit_q[i] != 0), registered-state-derived.
- Error cases:
  - released_i[i] with credit 0: the decrement is ignored and the credit stays 0; an assertion fires.
  - Credit overflow beyond TotalCapacity is a caller error; an assertion fires.
- Full: all NumSlots valid gives req_ready_o=0; valid requests stall with no loss.
- Ordering: credits are per ID, not per request. A short-delay younger request may effectively release an older same-ID response early; this is accepted model behaviour.

Optional Feature:
- SIMMEM_RELEASE_SCHED_STATS_EN defined:
  - Adds outputs occupancy_o [$clog2(NumSlots+1)] (current valid slots).
  - Adds max_occupancy_o (high-water mark, cleared only by reset).
  - Adds stall_cnt_o [31:0] (cycles with req_valid_i && !req_ready_o, saturating at all-ones).
- Undefined: these ports and their registers are absent; core behaviour is identical.

Decomposition:
- simmem_pkg holds:
  - IDWidth, NumIds, DelayWidth.
  - Types id_t, delay_t, credit_t.
  - Struct slot_t {valid, id, cnt}.
- Sub-module simmem_delay_slot: one countdown slot.
  - Inputs: load, id, delay.
  - Outputs: valid, id, expire pulse.
  - Instantiated NumSlots times.
- Credit counters, lowest-free priority encoder and stats stay in the top module.

Test Plan:
- Single request id=3, delay=5 accepted at edge 0 -> release_en_o[3] rises after edge 6. The bank pulses released_i[3] once -> release_en_o[3] low next cycle.
- Delay 0 on id=0 -> release_en_o[0] high after one edge. Delay 255 -> high after 256 edges.
- Eight requests held valid back-to-back -> req_ready_o=0 after the 8th accept. The 9th stalls until the first slot expires, then is accepted the cycle after the free is reported.
- Three requests id=7 with equal delay accepted consecutively, plus two same-delay issued the same… -> credit reaches count matching expiries; three released_i[7] pulses return release_en_o[7] to 0. An expiry coinciding with a release keeps the credit unchanged.
- released_i[2] pulsed with zero credit -> release_en_o[2] stays 0 and the assertion is flagged.
- Reset asserted with 4 slots pending and 2 credits -> all outputs 0 immediately. After release, no release_en_o bit rises within 300 cycles without new requests.
